// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and elaboration helpers for the Rijndael ShiftRows datapath.
//   ciph_op_e        : per-beat direction (CIPH_FWD = ShiftRows, CIPH_INV = InvShiftRows)
//   AES_LEGAL_NB     : column counts the permutation supports
//   aes_shift_offset : row rotation amount C_r for a given block width
//   aes_nb_legal     : membership test against AES_LEGAL_NB
// ---------------------------------------------------------------------------
package aes_pkg;

   typedef enum logic {
      CIPH_FWD = 1'b0,
      CIPH_INV = 1'b1
   } ciph_op_e;

   localparam int AES_LEGAL_NB [3] = '{4, 6, 8};

   // Rijndael offsets: 0,1,2,3 for NB=4/6; 0,1,3,4 for NB=8.
   function automatic int aes_shift_offset(input int nb, input int row);
      if (nb == 8 && row >= 2) begin
         return row + 1;
      end
      return row;
   endfunction

   function automatic bit aes_nb_legal(input int nb);
      for (int unsigned i = 0; i < 3; i++) begin
         if (AES_LEGAL_NB[i] == nb) begin
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

endpackage

// File: rtl/aes_pipe_stage.sv
// ---------------------------------------------------------------------------
// aes_pipe_stage
// One elastic register slice (valid/ready/data) with synchronous clear.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : synchronous flush (valid and data forced to zero)
//   i_valid/o_ready/i_data   : upstream handshake
//   o_valid/i_ready/o_data   : downstream handshake (o_data held while stalled)
// ---------------------------------------------------------------------------
module aes_pipe_stage #(
   parameter int WIDTH = 128
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             w_ready;

   // Slot can take a beat when empty or when its current beat leaves this cycle.
   assign w_ready = ~r_valid | i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_ready) begin
         r_valid <= i_valid;
         // Data only moves on a real transfer, so nothing undriven ever enters.
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

   assign o_ready = w_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// aes_shift_rows_pipe
// Registered, back-pressured Rijndael ShiftRows / InvShiftRows for a 4 x NB state.
// The permutation is combinational ahead of the first stage; the NUM_STAGES
// elastic slices carry already-permuted data, so direction needs no storage.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   clear_i                 : synchronous flush of every stage
//   in_valid_i / in_ready_o : input handshake (in_ready_o low during clear_i)
//   op_i                    : CIPH_FWD or CIPH_INV for the offered beat
//   data_i / data_o         : row-major state, byte(r,c) at [(r*NB+c)*8 +: 8]
//   out_valid_o/out_ready_i : output handshake
//   idle_o                  : no stage holds a beat
// ---------------------------------------------------------------------------
module aes_shift_rows_pipe
   import aes_pkg::*;
#(
   parameter int NB         = 4,
   parameter int NUM_STAGES = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  ciph_op_e        op_i,
   input  logic [32*NB-1:0] data_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [32*NB-1:0] data_o,
   output logic            idle_o
);

   localparam int W = 32 * NB;

   if (!aes_nb_legal(NB)) begin : g_bad_nb
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (NUM_STAGES < 1 || NUM_STAGES > 4) begin : g_bad_stages
      $error("aes_shift_rows_pipe: NUM_STAGES must be 1..4");
   end

   logic [W-1:0] w_fwd;
   logic [W-1:0] w_inv;
   logic [W-1:0] w_perm;

   // Source columns resolved at elaboration; the +NB keeps the inverse index non-negative.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int SH    = aes_shift_offset(NB, r);
         localparam int SRC_F = (c + SH) % NB;
         localparam int SRC_I = (c + NB - SH) % NB;
         assign w_fwd[(r*NB+c)*8 +: 8] = data_i[(r*NB+SRC_F)*8 +: 8];
         assign w_inv[(r*NB+c)*8 +: 8] = data_i[(r*NB+SRC_I)*8 +: 8];
      end
   end

   assign w_perm = (op_i == CIPH_INV) ? w_inv : w_fwd;

   // Index k is the link feeding stage k; index NUM_STAGES is the output port.
   logic [NUM_STAGES:0] w_valid;
   logic [NUM_STAGES:0] w_ready;
   logic [W-1:0]        w_data [NUM_STAGES+1];

   assign w_valid[0]          = in_valid_i & ~clear_i;
   assign w_data[0]           = w_perm;
   assign w_ready[NUM_STAGES] = out_ready_i;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      aes_pipe_stage #(.WIDTH(W)) u_stage (
         .i_clk   (clk_i),
         .i_rst_n (rst_ni),
         .i_clear (clear_i),
         .i_valid (w_valid[k]),
         .o_ready (w_ready[k]),
         .i_data  (w_data[k]),
         .o_valid (w_valid[k+1]),
         .i_ready (w_ready[k+1]),
         .o_data  (w_data[k+1])
      );
   end

   assign in_ready_o  = w_ready[0] & ~clear_i;
   assign out_valid_o = w_valid[NUM_STAGES];
   assign data_o      = w_data[NUM_STAGES];
   assign idle_o      = ~|w_valid[NUM_STAGES:1];

endmodule
